// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction memory responder: bus widths,
// default configuration constants and the responder FSM encoding.
package imem_responder_pkg;

  // Bus widths are given as MSB index (width minus one).
  localparam int ADDR_SIZE  = 31;
  localparam int INSTR_SIZE = 31;

  // Default configuration of the responder.
  localparam int                 IMEM_DEPTH_WORDS = 1024;
  localparam int                 IMEM_WAIT_CYCLES = 1;
  localparam logic [ADDR_SIZE:0] IMEM_BASE_ADDR   = 32'h0000_0000;

  // Responder FSM encoding.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } imem_state_e;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch-side read bus of the instruction memory responder. The fetch stage
// is the master; the memory responder is the slave.
interface imem_responder_if;
  import imem_responder_pkg::*;

  logic [ADDR_SIZE:0]  mem_rd_addr;
  logic                mem_rd_enable;
  logic                abort;
  logic                mem_rd_ready;
  logic [INSTR_SIZE:0] mem_rd_data;
  logic                mem_rd_error;

  modport master (
    output mem_rd_addr,
    output mem_rd_enable,
    output abort,
    input  mem_rd_ready,
    input  mem_rd_data,
    input  mem_rd_error
  );

  modport slave (
    input  mem_rd_addr,
    input  mem_rd_enable,
    input  abort,
    output mem_rd_ready,
    output mem_rd_data,
    output mem_rd_error
  );

endinterface

// File: rtl/imem_responder_array.sv
// Word storage for the instruction memory: one write port used for program
// download and one synchronous read port. The storage itself is never reset;
// only the read data register is. A write and a read of the same word on the
// same edge return the old word.
module imem_array
  import imem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter int IDX_W       = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [INSTR_SIZE:0] wr_data,
  input  logic                rd_en,
  input  logic                rd_zero,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [INSTR_SIZE:0] rd_data
);

  logic [INSTR_SIZE:0] mem_r [DEPTH_WORDS];
  logic [INSTR_SIZE:0] rd_data_r;

  // Program download write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_idx] <= wr_data;
    end
  end

  // Synchronous read port; a faulting read returns zero instead of storage
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_r <= {(INSTR_SIZE+1){1'b0}};
    end else if (rd_en) begin
      if (rd_zero) begin
        rd_data_r <= {(INSTR_SIZE+1){1'b0}};
      end else begin
        rd_data_r <= mem_r[rd_idx];
      end
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/imem_responder.sv
// Instruction memory responder: accepts one fetch at a time, waits
// WAIT_CYCLES cycles, then strobes mem_rd_ready for one cycle with the
// registered word. Define IMEM_ERR_EN to fault out-of-window reads (and drop
// out-of-window loads); otherwise the word index wraps modulo DEPTH_WORDS.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int                 DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter int                 WAIT_CYCLES = IMEM_WAIT_CYCLES,
  parameter logic [ADDR_SIZE:0] BASE_ADDR   = IMEM_BASE_ADDR
) (
  input  logic                clk,
  input  logic                reset,
  imem_responder_if.slave     bus,
  input  logic                ld_en,
  input  logic [ADDR_SIZE:0]  ld_addr,
  input  logic [INSTR_SIZE:0] ld_data
);

  localparam int               IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int               OFS_W     = ADDR_SIZE - 1;
  localparam logic [3:0]       WAIT_LD   = 4'(WAIT_CYCLES);
  localparam logic [OFS_W-1:0] DEPTH_OFS = OFS_W'(DEPTH_WORDS);

  imem_state_e         state_r;
  imem_state_e         state_nxt_s;
  logic [3:0]          cnt_r;
  logic [3:0]          cnt_nxt_s;
  logic [ADDR_SIZE:0]  addr_r;
  logic                ready_r;
  logic                err_r;
  logic                accept_s;
  logic                enter_resp_s;
  logic [ADDR_SIZE:0]  rd_addr_s;
  logic [ADDR_SIZE:0]  rd_diff_s;
  logic [ADDR_SIZE:0]  ld_diff_s;
  logic [IDX_W-1:0]    rd_idx_s;
  logic [IDX_W-1:0]    ld_idx_s;
  logic                rd_zero_s;
  logic                ld_we_s;
  logic [INSTR_SIZE:0] rd_data_s;
  logic                unused_s;

  // State, wait counter, captured address and response flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= {(ADDR_SIZE+1){1'b0}};
      ready_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (accept_s) begin
        addr_r <= bus.mem_rd_addr;
      end
      ready_r <= enter_resp_s;
      if (enter_resp_s) begin
        err_r <= rd_zero_s;
      end
    end
  end

  // Next state: abort wins in IDLE and WAIT, RESP always lasts one cycle
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.abort) begin
          state_nxt_s = IDLE;
        end else if (bus.mem_rd_enable) begin
          state_nxt_s = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (bus.abort) begin
          state_nxt_s = IDLE;
        end else if (cnt_r <= 4'd1) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: accept strobe, wait counter update, read launch on RESP entry
  always_comb begin
    accept_s     = 1'b0;
    enter_resp_s = 1'b0;
    cnt_nxt_s    = cnt_r;
    case (state_r)
      IDLE: begin
        if (state_nxt_s != IDLE) begin
          accept_s  = 1'b1;
          cnt_nxt_s = WAIT_LD;
        end else begin
          cnt_nxt_s = 4'd0;
        end
      end
      WAIT: begin
        if (state_nxt_s == WAIT) begin
          cnt_nxt_s = cnt_r - 4'd1;
        end else begin
          cnt_nxt_s = 4'd0;
        end
      end
      RESP:    cnt_nxt_s = 4'd0;
      default: cnt_nxt_s = 4'd0;
    endcase
    if ((state_nxt_s == RESP) && (state_r != RESP)) begin
      enter_resp_s = 1'b1;
    end else begin
      enter_resp_s = 1'b0;
    end
  end

  // Word indices; with zero wait states the read launches on the accept edge,
  // so the live request address is used while still in IDLE
  always_comb begin
    if (state_r == IDLE) begin
      rd_addr_s = bus.mem_rd_addr;
    end else begin
      rd_addr_s = addr_r;
    end
    rd_diff_s = rd_addr_s - BASE_ADDR;
    ld_diff_s = ld_addr - BASE_ADDR;
    rd_idx_s  = rd_diff_s[IDX_W+1:2];
    ld_idx_s  = ld_diff_s[IDX_W+1:2];
  end

`ifdef IMEM_ERR_EN
  // Out-of-window reads fault with zero data, out-of-window loads are dropped
  always_comb begin
    rd_zero_s = (rd_diff_s[ADDR_SIZE:2] >= DEPTH_OFS);
    ld_we_s   = ld_en && (ld_diff_s[ADDR_SIZE:2] < DEPTH_OFS);
  end
`else
  // Indices wrap modulo the depth; no access can fault
  always_comb begin
    rd_zero_s = 1'b0;
    ld_we_s   = ld_en;
  end
`endif

  // Byte-lane bits and, when wrapping, the upper offset bits carry no meaning
  assign unused_s = ^{rd_diff_s, ld_diff_s, DEPTH_OFS};

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_imem_array (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (ld_we_s),
    .wr_idx  (ld_idx_s),
    .wr_data (ld_data),
    .rd_en   (enter_resp_s),
    .rd_zero (rd_zero_s),
    .rd_idx  (rd_idx_s),
    .rd_data (rd_data_s)
  );

  assign bus.mem_rd_ready = ready_r;
  assign bus.mem_rd_data  = rd_data_s;
  assign bus.mem_rd_error = err_r;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: three instances with 1, 0 and 3 wait
// states (the last one with a non-zero base address). Inputs change 1 ns
// after the rising edge, outputs are sampled on the falling edge. Cycle c of
// a scenario is the period following the c-th edge after its request is
// first driven.
module tb_imem_responder;

  logic clk;
  logic reset;
  int   total_cnt;
  int   bad_cnt;

  logic        ld_en1, ld_en0, ld_en3;
  logic [31:0] ld_addr1, ld_addr0, ld_addr3;
  logic [31:0] ld_data1, ld_data0, ld_data3;

  imem_responder_if if_w1 ();
  imem_responder_if if_w0 ();
  imem_responder_if if_w3 ();

  imem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1), .BASE_ADDR(32'h0000_0000)) u_w1 (
    .clk(clk), .reset(reset), .bus(if_w1),
    .ld_en(ld_en1), .ld_addr(ld_addr1), .ld_data(ld_data1));

  imem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_0000)) u_w0 (
    .clk(clk), .reset(reset), .bus(if_w0),
    .ld_en(ld_en0), .ld_addr(ld_addr0), .ld_data(ld_data0));

  imem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(3), .BASE_ADDR(32'h0000_0100)) u_w3 (
    .clk(clk), .reset(reset), .bus(if_w3),
    .ld_en(ld_en3), .ld_addr(ld_addr3), .ld_data(ld_data3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Write one word through the load port of the selected instance.
  task automatic load(input int which, input logic [31:0] a, input logic [31:0] d);
    case (which)
      0:       begin ld_en0 = 1'b1; ld_addr0 = a; ld_data0 = d; end
      1:       begin ld_en1 = 1'b1; ld_addr1 = a; ld_data1 = d; end
      default: begin ld_en3 = 1'b1; ld_addr3 = a; ld_data3 = d; end
    endcase
    next_cycle();
    ld_en0 = 1'b0;
    ld_en1 = 1'b0;
    ld_en3 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) next_cycle();
    reset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({if_w1.mem_rd_ready, if_w1.mem_rd_error, if_w1.mem_rd_data} !== 34'h0) begin
      bad_cnt++;
      $display("FAIL reset_w1: rdy=%b err=%b data=%h, want all 0", if_w1.mem_rd_ready, if_w1.mem_rd_error, if_w1.mem_rd_data);
    end
    total_cnt++;
    if ({if_w0.mem_rd_ready, if_w0.mem_rd_error, if_w0.mem_rd_data} !== 34'h0) begin
      bad_cnt++;
      $display("FAIL reset_w0: rdy=%b err=%b data=%h, want all 0", if_w0.mem_rd_ready, if_w0.mem_rd_error, if_w0.mem_rd_data);
    end
    total_cnt++;
    if ({if_w3.mem_rd_ready, if_w3.mem_rd_error, if_w3.mem_rd_data} !== 34'h0) begin
      bad_cnt++;
      $display("FAIL reset_w3: rdy=%b err=%b data=%h, want all 0", if_w3.mem_rd_ready, if_w3.mem_rd_error, if_w3.mem_rd_data);
    end
    next_cycle();
  endtask

  // One wait state: response in cycle 2, ready for that cycle only.
  task automatic test_basic();
    logic exp_rdy;
    load(1, 32'h0000_0000, 32'h0000_0013);
    if_w1.mem_rd_addr   = 32'h0000_0000;
    if_w1.mem_rd_enable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      exp_rdy = (c == 2);
      total_cnt++;
      if (if_w1.mem_rd_ready !== exp_rdy) begin
        bad_cnt++;
        $display("FAIL basic_ready c%0d: got %b want %b", c, if_w1.mem_rd_ready, exp_rdy);
      end
      if (c == 2) begin
        total_cnt++;
        if (if_w1.mem_rd_data !== 32'h0000_0013) begin
          bad_cnt++;
          $display("FAIL basic_data: got %h want 00000013", if_w1.mem_rd_data);
        end
        total_cnt++;
        if (if_w1.mem_rd_error !== 1'b0) begin
          bad_cnt++;
          $display("FAIL basic_error: got %b want 0", if_w1.mem_rd_error);
        end
      end
      next_cycle();
      if (c == 2) if_w1.mem_rd_enable = 1'b0;
    end
  endtask

  // Zero wait states, enable held: responses on cycles 1 and 3.
  task automatic test_back_to_back();
    logic exp_rdy;
    load(0, 32'h0000_0000, 32'h1111_1111);
    load(0, 32'h0000_0004, 32'h2222_2222);
    if_w0.mem_rd_addr   = 32'h0000_0000;
    if_w0.mem_rd_enable = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      exp_rdy = (c == 1) || (c == 3);
      total_cnt++;
      if (if_w0.mem_rd_ready !== exp_rdy) begin
        bad_cnt++;
        $display("FAIL b2b_ready c%0d: got %b want %b", c, if_w0.mem_rd_ready, exp_rdy);
      end
      if ((c == 1) || (c == 2)) begin
        total_cnt++;
        if (if_w0.mem_rd_data !== 32'h1111_1111) begin
          bad_cnt++;
          $display("FAIL b2b_data0 c%0d: got %h want 11111111", c, if_w0.mem_rd_data);
        end
      end
      if (c == 3) begin
        total_cnt++;
        if (if_w0.mem_rd_data !== 32'h2222_2222) begin
          bad_cnt++;
          $display("FAIL b2b_data1: got %h want 22222222", if_w0.mem_rd_data);
        end
      end
      next_cycle();
      if (c == 1) if_w0.mem_rd_addr = 32'h0000_0004;
      if (c == 3) if_w0.mem_rd_enable = 1'b0;
    end
  endtask

  // Three wait states, base 0x100: abort in cycles 2-3 kills the first fetch
  // and blocks a re-accept; the next fetch (misaligned 0x10E -> word 0x10C)
  // is accepted at the end of cycle 4 and answered in cycle 8.
  task automatic test_abort();
    logic exp_rdy;
    load(3, 32'h0000_0100, 32'hA0A0_A0A0);
    load(3, 32'h0000_010C, 32'hCAFE_F00D);
    if_w3.mem_rd_addr   = 32'h0000_0100;
    if_w3.mem_rd_enable = 1'b1;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      exp_rdy = (c == 8);
      total_cnt++;
      if (if_w3.mem_rd_ready !== exp_rdy) begin
        bad_cnt++;
        $display("FAIL abort_ready c%0d: got %b want %b", c, if_w3.mem_rd_ready, exp_rdy);
      end
      if (c == 8) begin
        total_cnt++;
        if (if_w3.mem_rd_data !== 32'hCAFE_F00D) begin
          bad_cnt++;
          $display("FAIL abort_data: got %h want cafef00d", if_w3.mem_rd_data);
        end
      end
      next_cycle();
      if (c == 1) if_w3.abort = 1'b1;
      if (c == 3) begin
        if_w3.abort       = 1'b0;
        if_w3.mem_rd_addr = 32'h0000_010E;
      end
      if (c == 8) if_w3.mem_rd_enable = 1'b0;
    end
  endtask

  // A load landing on the response edge returns old data; a repeat sees it.
  task automatic test_load_collision();
    load(1, 32'h0000_0008, 32'h5555_AAAA);
    for (int pass = 0; pass < 2; pass++) begin
      if_w1.mem_rd_addr   = 32'h0000_0008;
      if_w1.mem_rd_enable = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        total_cnt++;
        if (if_w1.mem_rd_ready !== (c == 2)) begin
          bad_cnt++;
          $display("FAIL collide_ready p%0d c%0d: got %b", pass, c, if_w1.mem_rd_ready);
        end
        if ((c == 2) && (pass == 0)) begin
          total_cnt++;
          if (if_w1.mem_rd_data !== 32'h5555_AAAA) begin
            bad_cnt++;
            $display("FAIL collide_old: got %h want 5555aaaa", if_w1.mem_rd_data);
          end
        end
        if ((c == 2) && (pass == 1)) begin
          total_cnt++;
          if (if_w1.mem_rd_data !== 32'hDEAD_BEEF) begin
            bad_cnt++;
            $display("FAIL collide_new: got %h want deadbeef", if_w1.mem_rd_data);
          end
        end
        next_cycle();
        if ((c == 0) && (pass == 0)) begin
          ld_en1   = 1'b1;
          ld_addr1 = 32'h0000_0008;
          ld_data1 = 32'hDEAD_BEEF;
        end
        if (c == 1) ld_en1 = 1'b0;
        if (c == 2) if_w1.mem_rd_enable = 1'b0;
      end
    end
  endtask

  // Read of 0x1000 (index 1024) then a load to 0x1000 followed by a read of 0x0.
  task automatic test_out_of_range();
    logic [31:0] exp_data [2];
    logic        exp_err  [2];
    logic [31:0] req_addr [2];
`ifdef IMEM_ERR_EN
    exp_data[0] = 32'h0000_0000; exp_err[0] = 1'b1;
    exp_data[1] = 32'h0000_0013; exp_err[1] = 1'b0;
`else
    exp_data[0] = 32'h0000_0013; exp_err[0] = 1'b0;
    exp_data[1] = 32'hBAD0_BAD0; exp_err[1] = 1'b0;
`endif
    req_addr[0] = 32'h0000_1000;
    req_addr[1] = 32'h0000_0000;
    for (int r = 0; r < 2; r++) begin
      if (r == 1) load(1, 32'h0000_1000, 32'hBAD0_BAD0);
      if_w1.mem_rd_addr   = req_addr[r];
      if_w1.mem_rd_enable = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        total_cnt++;
        if (if_w1.mem_rd_ready !== (c == 2)) begin
          bad_cnt++;
          $display("FAIL range_ready r%0d c%0d: got %b", r, c, if_w1.mem_rd_ready);
        end
        if (c == 2) begin
          total_cnt++;
          if ((if_w1.mem_rd_data !== exp_data[r]) || (if_w1.mem_rd_error !== exp_err[r])) begin
            bad_cnt++;
            $display("FAIL range_resp r%0d: got data=%h err=%b want data=%h err=%b",
                     r, if_w1.mem_rd_data, if_w1.mem_rd_error, exp_data[r], exp_err[r]);
          end
        end
        next_cycle();
        if (c == 2) if_w1.mem_rd_enable = 1'b0;
      end
    end
  endtask

  // Reset during WAIT drops the fetch and clears outputs; storage survives.
  task automatic test_reset_mid();
    if_w3.mem_rd_addr   = 32'h0000_010C;
    if_w3.mem_rd_enable = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      total_cnt++;
      if (if_w3.mem_rd_ready !== 1'b0) begin
        bad_cnt++;
        $display("FAIL rstmid_ready c%0d: got %b want 0", c, if_w3.mem_rd_ready);
      end
      if (c == 2) begin
        total_cnt++;
        if ({if_w3.mem_rd_error, if_w3.mem_rd_data} !== 33'h0) begin
          bad_cnt++;
          $display("FAIL rstmid_outputs: got err=%b data=%h want 0", if_w3.mem_rd_error, if_w3.mem_rd_data);
        end
      end
      next_cycle();
      if (c == 0) begin
        reset               = 1'b1;
        if_w3.mem_rd_enable = 1'b0;
      end
      if (c == 1) reset = 1'b0;
    end
    if_w3.mem_rd_enable = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total_cnt++;
      if (if_w3.mem_rd_ready !== (c == 4)) begin
        bad_cnt++;
        $display("FAIL rstmid_reread_ready c%0d: got %b", c, if_w3.mem_rd_ready);
      end
      if (c == 4) begin
        total_cnt++;
        if (if_w3.mem_rd_data !== 32'hCAFE_F00D) begin
          bad_cnt++;
          $display("FAIL rstmid_storage: got %h want cafef00d", if_w3.mem_rd_data);
        end
      end
      next_cycle();
      if (c == 4) if_w3.mem_rd_enable = 1'b0;
    end
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    reset     = 1'b1;
    ld_en1 = 1'b0; ld_addr1 = 32'h0; ld_data1 = 32'h0;
    ld_en0 = 1'b0; ld_addr0 = 32'h0; ld_data0 = 32'h0;
    ld_en3 = 1'b0; ld_addr3 = 32'h0; ld_data3 = 32'h0;
    if_w1.mem_rd_addr = 32'h0; if_w1.mem_rd_enable = 1'b0; if_w1.abort = 1'b0;
    if_w0.mem_rd_addr = 32'h0; if_w0.mem_rd_enable = 1'b0; if_w0.abort = 1'b0;
    if_w3.mem_rd_addr = 32'h0; if_w3.mem_rd_enable = 1'b0; if_w3.abort = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_load_collision();
    test_out_of_range();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words stored; power of two.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1: wait states between request accept and response, range 0..15.
REQ-003 SHALL have parameter BASE_ADDR, default 0: byte address of word 0.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port mem_rd_addr  input  ADDR_SIZE+1  byte address of the fetch request.
REQ-007 SHALL have port mem_rd_enable  input  1  request valid; held by the initiator until mem_rd_ready.
REQ-008 SHALL have port mem_rd_ready  output  1  one-cycle response strobe.
REQ-009 SHALL have port mem_rd_data  output  INSTR_SIZE+1  instruction word, valid while mem_rd_ready=1.
REQ-010 SHALL have port mem_rd_error  output  1  access fault, valid while mem_rd_ready=1.
REQ-011 SHALL have port abort  input  1  fetch flush; cancels any outstanding request.
REQ-012 SHALL have ports ld_en input 1, ld_addr input ADDR_SIZE+1, ld_data input INSTR_SIZE+1: word load port used for program download.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-014 In IDLE with mem_rd_enable=1 and abort=0, SHALL capture mem_rd_addr, load wait counter with WAIT_CYCLES, and go to WAIT, or go to RESP directly if WAIT_CYCLES=0.
REQ-015 In WAIT, SHALL decrement the counter each cycle and go to RESP on the edge where the counter reaches 0.
REQ-016 Latency SHALL be WAIT_CYCLES+1 cycles from the accept edge to mem_rd_ready=1.
REQ-017 In RESP, SHALL assert mem_rd_ready for exactly one cycle, then return to IDLE; a new request SHALL be accepted no earlier than the following cycle, giving a back-to-back throughput of 1 per WAIT_CYCLES+2 cycles.
REQ-018 SHALL ignore mem_rd_enable in WAIT and RESP; no request queueing; a changed mem_rd_addr while busy SHALL have no effect.
REQ-019 Word index SHALL be (captured_addr - BASE_ADDR) >> 2; address bits [1:0] SHALL be ignored, because misalignment is flagged by the fetch stage.
REQ-020 mem_rd_data and mem_rd_error SHALL be registered on the edge entering RESP and SHALL hold their values until the next response.
REQ-021 Abort in IDLE or WAIT SHALL force IDLE with no response; abort SHALL win over a simultaneous mem_rd_enable.
REQ-022 Abort during the RESP cycle SHALL NOT suppress that cycle's mem_rd_ready; the initiator discards the response.
REQ-023 ld_en=1 SHALL write ld_data at index (ld_addr - BASE_ADDR) >> 2; a load SHALL be visible to a response registered on any later edge and SHALL NOT be visible to a response registered on the same edge (old data returned).
REQ-024 Out-of-range loads SHALL be dropped when IMEM_ERR_EN is defined and SHALL wrap when it is not.

Reset
REQ-025 Reset SHALL force IDLE, mem_rd_ready=0, mem_rd_data=0, mem_rd_error=0 and wait counter=0.
REQ-026 Reset mid-transaction SHALL drop the request with no response.
REQ-027 Storage contents SHALL NOT be reset.

Configuration
REQ-028 With IMEM_ERR_EN defined, an index >= DEPTH_WORDS (including addresses below BASE_ADDR) SHALL respond with mem_rd_error=1 and mem_rd_data=0 at normal latency.
REQ-029 Without IMEM_ERR_EN, the index SHALL wrap modulo DEPTH_WORDS and mem_rd_error SHALL be tied to 0.

Structure
REQ-030 FSM state encodings and the IMEM_* default constants SHALL live in the shared def_params file, alongside ADDR_SIZE and INSTR_SIZE.
REQ-031 Storage and the load write port SHALL be the sub-module imem_array, with one synchronous read port and one write port.

Verification
REQ-032 WAIT_CYCLES=1: load 0x00000013 at 0x0; request 0x0 at cycle 0 -> mem_rd_ready=1 with data 0x00000013 at cycle 2, for one cycle only.
REQ-033 WAIT_CYCLES=0: back-to-back requests 0x0 then 0x4, mem_rd_enable held -> responses on cycles 1 and 3.
REQ-034 WAIT_CYCLES=3: abort at cycle 2 after accept -> no mem_rd_ready; next request accepted with full latency of 4.
REQ-035 Load 0xDEADBEEF to 0x8 on the same edge the response for 0x8 is registered -> old data returned; a repeat read returns 0xDEADBEEF.
REQ-036 IMEM_ERR_EN defined, DEPTH_WORDS=1024: request 0x1000 -> mem_rd_error=1, data 0; undefined: same request returns the word at 0x0.
REQ-037 Reset asserted during WAIT -> no response; all outputs 0 on the next cycle.
